// File: rtl/mcs4_clock_gen_if.sv
// MCS-4 bus timing interface: stop/step control in, two-phase clocks, sync and status out.
interface mcs4_clock_gen_if;
   logic       stop_req;
   logic       step;
   logic       clk1;
   logic       clk2;
   logic       sync;
   logic [2:0] subcycle;
   logic       cycle_end;
   logic       stop_ack;

   modport master (
      input  stop_req, step,
      output clk1, clk2, sync, subcycle, cycle_end, stop_ack
   );

   modport slave (
      output stop_req, step,
      input  clk1, clk2, sync, subcycle, cycle_end, stop_ack
   );
endinterface

// File: rtl/mcs4_clock_gen.sv
// MCS-4 master timing sequencer: two-phase clk1/clk2, sync on X3, stop/single-step at cycle boundaries.
module mcs4_clock_gen #(
   parameter int unsigned P1_CYC = 4,
   parameter int unsigned G1_CYC = 2,
   parameter int unsigned P2_CYC = 4,
   parameter int unsigned G2_CYC = 2
) (
   input  logic                  sysclk,
   input  logic                  reset,
   mcs4_clock_gen_if.master      bus
);

   localparam logic [1:0] SLOT_P1 = 2'd0;
   localparam logic [1:0] SLOT_G1 = 2'd1;
   localparam logic [1:0] SLOT_P2 = 2'd2;
   localparam logic [1:0] SLOT_G2 = 2'd3;
   localparam logic [2:0] SUB_X3  = 3'd7;

   typedef enum logic [1:0] {ST_RUN, ST_STOPPED, ST_STEP} state_e;

   state_e     r_state;
   state_e     w_state_nxt;
   logic       w_advance;

   // Position registers name the slot whose outputs are emitted on the next sysclk.
   logic [1:0] r_slot;
   logic [7:0] r_count;
   logic [2:0] r_pos_sub;
   logic [1:0] w_slot_nxt;
   logic [7:0] w_count_nxt;
   logic [2:0] w_pos_sub_nxt;
   logic [7:0] w_slot_max;
   logic       w_slot_done;

   logic       r_clk1;
   logic       r_clk2;
   logic       r_sync;
   logic [2:0] r_subcycle;
   logic       r_cycle_end;
   logic       r_stop_ack;

   always_comb begin
      w_slot_max = 8'(P1_CYC - 1);
      case (r_slot)
         SLOT_P1: w_slot_max = 8'(P1_CYC - 1);
         SLOT_G1: w_slot_max = 8'(G1_CYC - 1);
         SLOT_P2: w_slot_max = 8'(P2_CYC - 1);
         default: w_slot_max = 8'(G2_CYC - 1);
      endcase
   end

   assign w_slot_done = (r_count == w_slot_max);

   always_comb begin
      w_count_nxt   = r_count + 8'd1;
      w_slot_nxt    = r_slot;
      w_pos_sub_nxt = r_pos_sub;
      if (w_slot_done) begin
         w_count_nxt = 8'd0;
         w_slot_nxt  = r_slot + 2'd1;
         if (r_slot == SLOT_G2) begin
            w_pos_sub_nxt = r_pos_sub + 3'd1;
         end
      end
   end

   // Stop decisions are taken only on the cycle_end sysclk, so a cycle never halts midway.
   always_comb begin
      w_state_nxt = r_state;
      w_advance   = 1'b1;
      case (r_state)
         ST_RUN, ST_STEP: begin
            if (r_cycle_end) begin
               w_state_nxt = bus.stop_req ? ST_STOPPED : ST_RUN;
               w_advance   = !bus.stop_req;
            end
         end
         ST_STOPPED: begin
            if (!bus.stop_req) begin
               w_state_nxt = ST_RUN;
            end else if (bus.step) begin
               w_state_nxt = ST_STEP;
            end else begin
               w_advance = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_slot      <= SLOT_P1;
         r_count     <= 8'd0;
         r_pos_sub   <= SUB_X3;
         r_clk1      <= 1'b0;
         r_clk2      <= 1'b0;
         r_sync      <= 1'b0;
         r_subcycle  <= SUB_X3;
         r_cycle_end <= 1'b0;
         r_stop_ack  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_advance) begin
            r_clk1      <= (r_slot == SLOT_P1);
            r_clk2      <= (r_slot == SLOT_P2);
            r_sync      <= (r_pos_sub == SUB_X3);
            r_subcycle  <= r_pos_sub;
            r_cycle_end <= (r_pos_sub == SUB_X3) && (r_slot == SLOT_G2) && w_slot_done;
            r_stop_ack  <= 1'b0;
            r_slot      <= w_slot_nxt;
            r_count     <= w_count_nxt;
            r_pos_sub   <= w_pos_sub_nxt;
         end else begin
            r_clk1      <= 1'b0;
            r_clk2      <= 1'b0;
            r_sync      <= 1'b0;
            r_subcycle  <= SUB_X3;
            r_cycle_end <= 1'b0;
            r_stop_ack  <= 1'b1;
         end
      end
   end

   assign bus.clk1      = r_clk1;
   assign bus.clk2      = r_clk2;
   assign bus.sync      = r_sync;
   assign bus.subcycle  = r_subcycle;
   assign bus.cycle_end = r_cycle_end;
   assign bus.stop_ack  = r_stop_ack;

endmodule

// File: tb/tb_mcs4_clock_gen.sv
// Directed bench for mcs4_clock_gen with default timing (12 sysclk/subcycle, 96/instruction cycle).
module tb_mcs4_clock_gen;

   logic sysclk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   k;

   localparam logic [7:0] VEC_RESET   = 8'b000_111_0_0;
   localparam logic [7:0] VEC_STOPPED = 8'b000_111_0_1;

   mcs4_clock_gen_if bus ();

   mcs4_clock_gen #(
      .P1_CYC(4), .G1_CYC(2), .P2_CYC(4), .G2_CYC(2)
   ) dut (
      .sysclk (sysclk),
      .reset  (reset),
      .bus    (bus)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // {clk1, clk2, sync, subcycle[2:0], cycle_end, stop_ack}
   function automatic logic [7:0] obs();
      return {bus.clk1, bus.clk2, bus.sync, bus.subcycle, bus.cycle_end, bus.stop_ack};
   endfunction

   // Expected running outputs kk sysclk after the first X3/P1 (stopped time excluded).
   function automatic logic [7:0] run_vec(input int kk);
      int s;
      logic [2:0] sub;
      s   = kk % 12;
      sub = 3'((7 + kk / 12) % 8);
      return {(s < 4), (s >= 6 && s < 10), (sub == 3'd7), sub, (sub == 3'd7 && s == 11), 1'b0};
   endfunction

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      reset = 1'b1;
      bus.stop_req = 1'b0;
      bus.step = 1'b0;
      repeat (5) tick();
      got = obs();
      n_tests++;
      if (got !== VEC_RESET) begin
         n_fail++;
         $display("FAIL reset_state: got %b expected %b", got, VEC_RESET);
      end
      reset = 1'b0;
      k = 0;
      for (int i = 0; i < 96; i++) begin
         tick();
         got = obs();
         n_tests++;
         if (got !== run_vec(k)) begin
            n_fail++;
            $display("FAIL first_cycle k=%0d: got %b expected %b", k, got, run_vec(k));
         end
         k++;
      end
   endtask

   // Long run with ignored step pulses and a stop_req glitch that misses cycle_end.
   task automatic test_overlap();
      logic [7:0] got;
      int ce_count;
      int last_ce;
      ce_count = 0;
      last_ce = -1;
      for (int i = 0; i < 9600; i++) begin
         bus.stop_req = ((k % 96) >= 40 && (k % 96) < 43);
         bus.step     = ((k % 96) >= 60 && (k % 96) < 62);
         tick();
         got = obs();
         n_tests++;
         if (got !== run_vec(k)) begin
            n_fail++;
            $display("FAIL overlap_pattern k=%0d: got %b expected %b", k, got, run_vec(k));
         end
         n_tests++;
         if ((bus.clk1 & bus.clk2) !== 1'b0) begin
            n_fail++;
            $display("FAIL clk_overlap k=%0d: clk1=%b clk2=%b required not both 1", k, bus.clk1, bus.clk2);
         end
         if (bus.cycle_end === 1'b1) begin
            if (last_ce >= 0) begin
               n_tests++;
               if (k - last_ce != 96) begin
                  n_fail++;
                  $display("FAIL cycle_period: got %0d expected 96", k - last_ce);
               end
            end
            last_ce = k;
            ce_count++;
         end
         k++;
      end
      bus.stop_req = 1'b0;
      bus.step = 1'b0;
      n_tests++;
      if (ce_count != 100) begin
         n_fail++;
         $display("FAIL cycle_end_count: got %0d expected 100", ce_count);
      end
   endtask

   task automatic test_stop();
      logic [7:0] got;
      logic [7:0] exp;
      bit done;
      int budget;
      budget = 0;
      while (run_vec(k)[4:2] != 3'd3 && budget < 200) begin
         tick();
         k++;
         budget++;
      end
      bus.stop_req = 1'b1;
      done = 1'b0;
      budget = 0;
      while (!done && budget < 200) begin
         tick();
         got = obs();
         exp = run_vec(k);
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL stop_drain k=%0d: got %b expected %b", k, got, exp);
         end
         done = exp[1];
         k++;
         budget++;
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL stop_drain_timeout: got no cycle_end expected one within 200");
      end
      for (int i = 0; i < 200; i++) begin
         tick();
         got = obs();
         n_tests++;
         if (got !== VEC_STOPPED) begin
            n_fail++;
            $display("FAIL stopped_hold i=%0d: got %b expected %b", i, got, VEC_STOPPED);
         end
      end
   endtask

   task automatic test_step();
      logic [7:0] got;
      logic p1, p2, ps;
      int n1, n2, ns;
      n1 = 0; n2 = 0; ns = 0;
      p1 = 1'b0; p2 = 1'b0; ps = 1'b0;
      bus.step = 1'b1;
      for (int i = 0; i < 96; i++) begin
         tick();
         bus.step = 1'b0;
         got = obs();
         n_tests++;
         if (got !== run_vec(k)) begin
            n_fail++;
            $display("FAIL step_cycle k=%0d: got %b expected %b", k, got, run_vec(k));
         end
         if (bus.clk1 && !p1) n1++;
         if (bus.clk2 && !p2) n2++;
         if (bus.sync && !ps) ns++;
         p1 = bus.clk1; p2 = bus.clk2; ps = bus.sync;
         k++;
      end
      n_tests++;
      if (n1 != 8 || n2 != 8 || ns != 1) begin
         n_fail++;
         $display("FAIL step_pulses: got clk1=%0d clk2=%0d sync=%0d expected 8 8 1", n1, n2, ns);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         got = obs();
         n_tests++;
         if (got !== VEC_STOPPED) begin
            n_fail++;
            $display("FAIL step_restop i=%0d: got %b expected %b", i, got, VEC_STOPPED);
         end
      end
   endtask

   // Release with step also high: must resume free-running, no queued extra step.
   task automatic test_resume();
      logic [7:0] got;
      bus.stop_req = 1'b0;
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      got = obs();
      n_tests++;
      if (got !== 8'b100_000_0_0) begin
         n_fail++;
         $display("FAIL resume_first: got %b expected %b", got, 8'b100_000_0_0);
      end
      k++;
      for (int i = 0; i < 200; i++) begin
         tick();
         got = obs();
         n_tests++;
         if (got !== run_vec(k)) begin
            n_fail++;
            $display("FAIL resume_run k=%0d: got %b expected %b", k, got, run_vec(k));
         end
         k++;
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] got;
      int budget;
      budget = 0;
      while (!(run_vec(k)[4:2] == 3'd5 && (k % 12) == 7) && budget < 200) begin
         tick();
         k++;
         budget++;
      end
      n_tests++;
      if (bus.clk2 !== 1'b1 || bus.subcycle !== 3'd5) begin
         n_fail++;
         $display("FAIL mid_reset_setup: got clk2=%b sub=%0d expected 1 5", bus.clk2, bus.subcycle);
      end
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         got = obs();
         n_tests++;
         if (got !== VEC_RESET) begin
            n_fail++;
            $display("FAIL mid_reset i=%0d: got %b expected %b", i, got, VEC_RESET);
         end
      end
      reset = 1'b0;
      k = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         got = obs();
         n_tests++;
         if (got !== run_vec(k)) begin
            n_fail++;
            $display("FAIL post_reset k=%0d: got %b expected %b", k, got, run_vec(k));
         end
         k++;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      k = 0;
      reset = 1'b1;
      bus.stop_req = 1'b0;
      bus.step = 1'b0;
      test_reset();
      test_overlap();
      test_stop();
      test_step();
      test_resume();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
